// File: rtl/bp_uce_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bp_uce_mem_arbiter
// Purpose  : Round-robin share of one memory cmd/resp channel between I/D UCEs
//            with per-requester credit limits and in-order response routing.
// Revision : 1.0
// ============================================================================
module bp_uce_mem_arbiter #(
  parameter int msg_width_p = 512,
  parameter int credits_p   = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [2*msg_width_p-1:0] req_cmd_i,
  input  logic [1:0]               req_cmd_v_i,
  output logic [1:0]               req_cmd_ready_o,
  output logic [msg_width_p-1:0]   mem_cmd_o,
  output logic                     mem_cmd_v_o,
  input  logic                     mem_cmd_ready_i,
  input  logic [msg_width_p-1:0]   mem_resp_i,
  input  logic                     mem_resp_v_i,
  output logic                     mem_resp_yumi_o,
  output logic [msg_width_p-1:0]   req_resp_o,
  output logic [1:0]               req_resp_v_o,
  input  logic [1:0]               req_resp_yumi_i,
  output logic [1:0]               credits_full_o,
  output logic [1:0]               credits_empty_o,
  output logic                     err_o
);

  localparam int credit_width_lp = $clog2(credits_p + 1);
  localparam int fifo_els_lp     = 2 * credits_p;
  localparam int ptr_width_lp    = (fifo_els_lp > 1) ? $clog2(fifo_els_lp) : 1;
  localparam int occ_width_lp    = $clog2(fifo_els_lp + 1);

  localparam logic [credit_width_lp-1:0] c_credits_max = credit_width_lp'(credits_p);
  localparam logic [ptr_width_lp-1:0]    c_ptr_last    = ptr_width_lp'(fifo_els_lp - 1);
  localparam logic [occ_width_lp-1:0]    c_fifo_els    = occ_width_lp'(fifo_els_lp);

  // Grant-history FIFO: one requester id per accepted command, in issue order
  logic [fifo_els_lp-1:0]  r_fifo_ids;
  logic [ptr_width_lp-1:0] r_wptr;
  logic [ptr_width_lp-1:0] r_rptr;
  logic [occ_width_lp-1:0] r_occ;
  logic                    r_last;
  logic                    r_err;

  logic [1:0] w_full_cr;
  logic [1:0] w_empty_cr;
  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic [1:0] w_elig;
  logic       w_grant_v;
  logic       w_grant_id;
  logic [1:0] w_cmd_ready;
  logic       w_fire;
  logic       w_head;
  logic       w_route_v;
  logic [1:0] w_resp_v;
  logic       w_pop;

  assign w_fifo_full  = (r_occ == c_fifo_els);
  assign w_fifo_empty = (r_occ == '0);

  // reset_n_i gating forces the handshake outputs low the instant reset asserts
  assign w_elig = req_cmd_v_i & ~w_full_cr & {2{~w_fifo_full}} & {2{reset_n_i}};

  always_comb begin
    w_grant_v  = |w_elig;
    w_grant_id = 1'b0;
    case (w_elig)
      2'b01:   w_grant_id = 1'b0;
      2'b10:   w_grant_id = 1'b1;
      2'b11:   w_grant_id = ~r_last;
      default: w_grant_id = 1'b0;
    endcase
  end

  always_comb begin
    w_cmd_ready = 2'b00;
    if (w_grant_v) begin
      w_cmd_ready[w_grant_id] = mem_cmd_ready_i;
    end
  end

  assign w_fire          = w_grant_v & mem_cmd_ready_i;
  assign req_cmd_ready_o = w_cmd_ready;
  assign mem_cmd_v_o     = w_grant_v;
  assign mem_cmd_o       = !w_grant_v ? '0 :
                           (w_grant_id ? req_cmd_i[2*msg_width_p-1:msg_width_p]
                                       : req_cmd_i[msg_width_p-1:0]);

  assign w_head    = r_fifo_ids[r_rptr];
  assign w_route_v = mem_resp_v_i & ~w_fifo_empty & reset_n_i;

  always_comb begin
    w_resp_v = 2'b00;
    if (w_route_v) begin
      w_resp_v[w_head] = 1'b1;
    end
  end

  assign w_pop           = w_route_v & req_resp_yumi_i[w_head];
  assign req_resp_o      = mem_resp_i;
  assign req_resp_v_o    = w_resp_v;
  assign mem_resp_yumi_o = w_pop;
  assign credits_full_o  = w_full_cr;
  assign credits_empty_o = w_empty_cr;
  assign err_o           = r_err;

  // Per-requester outstanding counters; a same-cycle issue and return cancel out
  for (genvar r = 0; r < 2; r++) begin : g_cnt
    localparam logic c_id = 1'(r);
    logic [credit_width_lp-1:0] r_count;
    logic                       w_inc;
    logic                       w_dec;

    assign w_inc = w_fire & (w_grant_id == c_id);
    assign w_dec = w_pop & (w_head == c_id);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        r_count <= '0;
      end else if (w_inc && !w_dec && (r_count != c_credits_max)) begin
        r_count <= r_count + credit_width_lp'(1);
      end else if (w_dec && !w_inc && (r_count != '0)) begin
        r_count <= r_count - credit_width_lp'(1);
      end
    end

    assign w_full_cr[r]  = (r_count == c_credits_max);
    assign w_empty_cr[r] = (r_count == '0);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_fifo_ids <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_occ      <= '0;
      r_last     <= 1'b1;
      r_err      <= 1'b0;
    end else begin
      if (w_fire) begin
        r_fifo_ids[r_wptr] <= w_grant_id;
        r_wptr             <= (r_wptr == c_ptr_last) ? '0 : r_wptr + ptr_width_lp'(1);
        r_last             <= w_grant_id;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == c_ptr_last) ? '0 : r_rptr + ptr_width_lp'(1);
      end
      case ({w_fire, w_pop})
        2'b10:   r_occ <= r_occ + occ_width_lp'(1);
        2'b01:   r_occ <= r_occ - occ_width_lp'(1);
        default: r_occ <= r_occ;
      endcase
      // A response with nothing outstanding cannot be routed; flag it until reset
      if (mem_resp_v_i && w_fifo_empty) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_uce_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_uce_mem_arbiter
// Purpose  : Directed bench with requester-id scoreboard for bp_uce_mem_arbiter.
// Revision : 1.0
// ============================================================================
module tb_bp_uce_mem_arbiter;

  localparam int W  = 16;
  localparam int CR = 4;

  logic           clk_i = 1'b0;
  logic           reset_n_i;
  logic [2*W-1:0] req_cmd_i;
  logic [1:0]     req_cmd_v_i;
  logic [1:0]     req_cmd_ready_o;
  logic [W-1:0]   mem_cmd_o;
  logic           mem_cmd_v_o;
  logic           mem_cmd_ready_i;
  logic [W-1:0]   mem_resp_i;
  logic           mem_resp_v_i;
  logic           mem_resp_yumi_o;
  logic [W-1:0]   req_resp_o;
  logic [1:0]     req_resp_v_o;
  logic [1:0]     req_resp_yumi_i;
  logic [1:0]     credits_full_o;
  logic [1:0]     credits_empty_o;
  logic           err_o;

  bp_uce_mem_arbiter #(
    .msg_width_p(W),
    .credits_p  (CR)
  ) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .req_cmd_i      (req_cmd_i),
    .req_cmd_v_i    (req_cmd_v_i),
    .req_cmd_ready_o(req_cmd_ready_o),
    .mem_cmd_o      (mem_cmd_o),
    .mem_cmd_v_o    (mem_cmd_v_o),
    .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_i     (mem_resp_i),
    .mem_resp_v_i   (mem_resp_v_i),
    .mem_resp_yumi_o(mem_resp_yumi_o),
    .req_resp_o     (req_resp_o),
    .req_resp_v_o   (req_resp_v_o),
    .req_resp_yumi_i(req_resp_yumi_i),
    .credits_full_o (credits_full_o),
    .credits_empty_o(credits_empty_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk   = 0;
  int n_fail  = 0;
  int step_no = 0;
  int mdl_cnt [2];
  logic mdl_err;
  bit   sb_q [$];   // expected requester id of each outstanding command

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    req_cmd_v_i     = 2'b00;
    req_cmd_i       = '0;
    mem_cmd_ready_i = 1'b0;
    mem_resp_v_i    = 1'b0;
    mem_resp_i      = '0;
    req_resp_yumi_i = 2'b00;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"},  32'(req_cmd_ready_o), 32'h0);
    chk({tag, "_cmd_v"},      32'(mem_cmd_v_o),     32'h0);
    chk({tag, "_resp_v"},     32'(req_resp_v_o),    32'h0);
    chk({tag, "_resp_yumi"},  32'(mem_resp_yumi_o), 32'h0);
    chk({tag, "_cr_empty"},   32'(credits_empty_o), 32'h3);
    chk({tag, "_cr_full"},    32'(credits_full_o),  32'h0);
    chk({tag, "_err"},        32'(err_o),           32'h0);
  endtask

  // One clock: drive v/ready/resp, check at negedge, commit the model at posedge.
  // exp_g = expected granted requester, -1 for no grant.
  task automatic cyc(input logic [1:0] v, input logic rdy, input int exp_g,
                     input logic rv, input logic [1:0] yumi);
    logic [W-1:0] pay0, pay1, rp, exp_cmd;
    logic [1:0]   exp_rv, exp_rdy;
    logic         exp_yumi;
    bit           head;
    step_no++;
    pay0 = 16'hA000 + 16'(step_no);
    pay1 = 16'hB000 + 16'(step_no);
    rp   = 16'($urandom);
    req_cmd_v_i     = v;
    req_cmd_i       = {pay1, pay0};
    mem_cmd_ready_i = rdy;
    mem_resp_v_i    = rv;
    mem_resp_i      = rp;
    req_resp_yumi_i = yumi;
    @(negedge clk_i);
    chk("credits_full",  32'(credits_full_o),  32'({mdl_cnt[1] == CR, mdl_cnt[0] == CR}));
    chk("credits_empty", 32'(credits_empty_o), 32'({mdl_cnt[1] == 0, mdl_cnt[0] == 0}));
    chk("err",           32'(err_o),           32'(mdl_err));
    chk("cmd_v",         32'(mem_cmd_v_o),     32'(exp_g >= 0));
    exp_cmd = '0;
    exp_rdy = 2'b00;
    if (exp_g == 0) begin exp_cmd = pay0; exp_rdy = {1'b0, rdy}; end
    if (exp_g == 1) begin exp_cmd = pay1; exp_rdy = {rdy, 1'b0}; end
    chk("cmd_data",  32'(mem_cmd_o),       32'(exp_cmd));
    chk("cmd_ready", 32'(req_cmd_ready_o), 32'(exp_rdy));
    exp_rv   = 2'b00;
    exp_yumi = 1'b0;
    head     = 1'b0;
    if (rv && sb_q.size() > 0) begin
      head         = sb_q[0];
      exp_rv[head] = 1'b1;
      exp_yumi     = yumi[head];
    end
    chk("resp_v",    32'(req_resp_v_o),    32'(exp_rv));
    chk("resp_yumi", 32'(mem_resp_yumi_o), 32'(exp_yumi));
    chk("resp_data", 32'(req_resp_o),      32'(rp));
    if (rv && sb_q.size() == 0) mdl_err = 1'b1;
    @(posedge clk_i);
    if (exp_yumi) begin
      void'(sb_q.pop_front());
      mdl_cnt[head]--;
    end
    if (exp_g >= 0 && rdy) begin
      sb_q.push_back(exp_g[0]);
      mdl_cnt[exp_g]++;
    end
    #1;
    idle_inputs();
  endtask

  task automatic idle_cyc();
    cyc(2'b00, 1'b0, -1, 1'b0, 2'b00);
  endtask

  initial begin
    mdl_cnt[0] = 0;
    mdl_cnt[1] = 0;
    mdl_err    = 1'b0;

    // Reset held with every input active: outputs must stay at reset values
    reset_n_i       = 1'b0;
    req_cmd_v_i     = 2'b11;
    req_cmd_i       = {16'h1111, 16'h2222};
    mem_cmd_ready_i = 1'b1;
    mem_resp_v_i    = 1'b1;
    mem_resp_i      = 16'h3333;
    req_resp_yumi_i = 2'b11;
    @(negedge clk_i);
    chk_reset_outputs("rst");
    #1;
    idle_inputs();
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Single requester: fill credits, 5th blocked, one return re-opens it
    repeat (4) cyc(2'b01, 1'b1, 0, 1'b0, 2'b00);
    cyc(2'b01, 1'b1, -1, 1'b0, 2'b00);
    cyc(2'b01, 1'b1, -1, 1'b1, 2'b01);
    cyc(2'b01, 1'b1, 0, 1'b0, 2'b00);
    repeat (4) cyc(2'b00, 1'b0, -1, 1'b1, 2'b01);

    // Contention: last grant was 0, so alternation starts with 1
    cyc(2'b11, 1'b1, 1, 1'b0, 2'b00);
    cyc(2'b11, 1'b1, 0, 1'b0, 2'b00);
    cyc(2'b11, 1'b1, 1, 1'b0, 2'b00);
    cyc(2'b11, 1'b1, 0, 1'b0, 2'b00);
    repeat (3) cyc(2'b11, 1'b0, 1, 1'b0, 2'b00);
    cyc(2'b11, 1'b1, 1, 1'b0, 2'b00);
    repeat (5) cyc(2'b00, 1'b0, -1, 1'b1, 2'b11);

    // In-order routing 1,0,0,1 with the first response held off for 2 cycles
    cyc(2'b10, 1'b1, 1, 1'b0, 2'b00);
    cyc(2'b01, 1'b1, 0, 1'b0, 2'b00);
    cyc(2'b01, 1'b1, 0, 1'b0, 2'b00);
    cyc(2'b10, 1'b1, 1, 1'b0, 2'b00);
    repeat (2) cyc(2'b00, 1'b0, -1, 1'b1, 2'b00);
    repeat (4) cyc(2'b00, 1'b0, -1, 1'b1, 2'b11);

    // Simultaneous issue and return on requester 0 at count 2
    cyc(2'b01, 1'b1, 0, 1'b0, 2'b00);
    cyc(2'b01, 1'b1, 0, 1'b0, 2'b00);
    cyc(2'b01, 1'b1, 0, 1'b1, 2'b01);
    repeat (2) cyc(2'b00, 1'b0, -1, 1'b1, 2'b01);

    // Spurious response with nothing outstanding
    cyc(2'b00, 1'b0, -1, 1'b1, 2'b11);
    repeat (2) idle_cyc();

    // Three outstanding, then reset asserted mid-cycle
    cyc(2'b01, 1'b1, 0, 1'b0, 2'b00);
    cyc(2'b10, 1'b1, 1, 1'b0, 2'b00);
    cyc(2'b01, 1'b1, 0, 1'b0, 2'b00);
    #2;
    req_cmd_v_i     = 2'b11;
    req_cmd_i       = {16'h4444, 16'h5555};
    mem_cmd_ready_i = 1'b1;
    mem_resp_v_i    = 1'b1;
    req_resp_yumi_i = 2'b11;
    reset_n_i       = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    sb_q.delete();
    mdl_cnt[0] = 0;
    mdl_cnt[1] = 0;
    mdl_err    = 1'b0;
    idle_inputs();
    #3;
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    cyc(2'b11, 1'b1, 0, 1'b0, 2'b00);
    cyc(2'b00, 1'b0, -1, 1'b1, 2'b01);
    idle_cyc();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
